fetch_issue: RTL and testbench
==============================

FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, the instruction-memory word-address width.
REQ-002 The module SHALL have parameter CNT_W, default 16, the issued-instruction counter width.
REQ-003 The module SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port imem_addr  output  ADDR_W  word address to synchronous-read instruction memory.
REQ-006 The module SHALL have port imem_q  input  32  instruction memory data, valid one cycle after imem_addr.
REQ-007 The module SHALL have port ready  input  1  decode stage accepts the presented instruction this cycle.
REQ-008 The module SHALL have port redirect  input  1  branch/jump taken; discard current fetch and restart at redirect_target.
REQ-009 The module SHALL have port redirect_target  input  ADDR_W  new PC on redirect.
REQ-010 The module SHALL have port valid  output  1  instr/opcode/isR/pc_out hold a fetched instruction.
REQ-011 The module SHALL have port instr  output  32  registered instruction word.
REQ-012 The module SHALL have port opcode  output  5  instr[31:27].
REQ-013 The module SHALL have port isR  output  1  high when opcode == 5'b00000.
REQ-014 The module SHALL have port pc_out  output  ADDR_W  address of the presented instruction.
REQ-015 The module SHALL have port issued  output  CNT_W  count of accepted instructions.

Function
REQ-016 The module SHALL implement a three-state FSM: FETCH, WAIT, ISSUE.
REQ-017 imem_addr SHALL equal the PC register combinationally in every state.
REQ-018 FETCH SHALL transition to WAIT unconditionally (absent redirect).
REQ-019 WAIT SHALL capture imem_q into instr, set valid=1, and transition to ISSUE at the clock edge ending WAIT.
REQ-020 ISSUE SHALL hold instr, pc_out, valid stable while ready=0 and redirect=0.
REQ-021 In ISSUE with ready=1 and redirect=0, the module SHALL increment PC by 1 (modulo 2^ADDR_W), increment issued, clear valid, and enter FETCH.
REQ-022 redirect=1 in any state SHALL load PC with redirect_target, clear valid, leave issued unchanged, and enter FETCH next cycle; redirect has priority over ready.
REQ-023 An in-flight imem_q read discarded by redirect in WAIT SHALL never reach instr.
REQ-024 PC at 2^ADDR_W-1 accepted in ISSUE SHALL wrap to 0.
REQ-025 issued SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-026 opcode and isR SHALL be derived combinationally from the instr register, so they change only when instr changes.
REQ-027 Minimum issue interval SHALL be 3 cycles (FETCH, WAIT, ISSUE with ready=1).
REQ-028 pc_out SHALL equal the PC value from which instr was fetched.

Reset
REQ-029 reset=1 at a rising edge SHALL set state=FETCH, PC=0, valid=0, instr=0, issued=0; hence opcode=0, isR=1, pc_out=0.
REQ-030 reset SHALL take priority over redirect and ready, including mid-WAIT and mid-ISSUE.
REQ-031 The first fetch after reset deassertion SHALL present imem_addr=0 in that cycle.

Verification
REQ-032 Reset then ready=1 constant, imem[0]=0x28000000 -> valid=1 on 3rd cycle after reset release, opcode=5'b00101, isR=0, pc_out=0; issued=1 after handshake.
REQ-033 imem[1]=0x00000000, ready=0 for 5 cycles in ISSUE -> valid, instr, pc_out=1 held unchanged all 5 cycles; issued unchanged; isR=1.
REQ-034 redirect=1, redirect_target=0x040 during WAIT -> stale imem_q never appears on instr; next valid shows pc_out=0x040.
REQ-035 redirect=1 and ready=1 same cycle in ISSUE at pc=5 -> PC=target, issued not incremented, valid=0 next cycle.
REQ-036 PC preset via redirect to 0xFFF, ready=1 -> after acceptance imem_addr=0x000.
REQ-037 reset=1 asserted mid-ISSUE with valid=1 -> next cycle valid=0, pc_out=0, issued=0, imem_addr=0.

Source files
------------

// File: rtl/fetch_issue_if.sv
// Fetch/issue bus: instruction-memory port plus decode-side handshake and status.
// The master side belongs to the fetch unit. The slave side belongs to memory and decode.
interface fetch_issue_if #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_q;
    logic              ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              valid;
    logic [31:0]       instr;
    logic [4:0]        opcode;
    logic              isR;
    logic [ADDR_W-1:0] pc_out;
    logic [CNT_W-1:0]  issued;

    modport master (
        output imem_addr, valid, instr, opcode, isR, pc_out, issued,
        input  imem_q, ready, redirect, redirect_target
    );

    modport slave (
        input  imem_addr, valid, instr, opcode, isR, pc_out, issued,
        output imem_q, ready, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_issue.sv
// Fetch/issue unit: fetches one word from synchronous instruction memory, presents it to decode
// until it is accepted, and counts accepted instructions with a saturating counter.
module fetch_issue #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic          clock,
    input  logic          reset,
    fetch_issue_if.master bus
);
    typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              valid_r;
    logic [31:0]       instr_r;
    logic [ADDR_W-1:0] pc_out_r;
    logic [CNT_W-1:0]  issued_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A redirect in WAIT abandons the read in flight, so that data is never captured into instr.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            valid_r  <= 1'b0;
            instr_r  <= '0;
            pc_out_r <= '0;
            issued_r <= '0;
        end else if (bus.redirect) begin
            state   <= FETCH;
            pc      <= bus.redirect_target;
            valid_r <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= WAIT;
                WAIT: begin
                    instr_r  <= bus.imem_q;
                    pc_out_r <= pc;
                    valid_r  <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (bus.ready) begin
                        pc       <= pc + ADDR_W'(1);
                        issued_r <= sat_inc(issued_r);
                        valid_r  <= 1'b0;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign bus.valid     = valid_r;
    assign bus.instr     = instr_r;
    assign bus.opcode    = instr_r[31:27];
    assign bus.isR       = (instr_r[31:27] == 5'b00000);
    assign bus.pc_out    = pc_out_r;
    assign bus.issued    = issued_r;
endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue. It models the synchronous instruction memory and checks reset,
// issue, stall, redirect, PC wrap and counter saturation against hand-computed values.
module tb_fetch_issue;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 4;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    fetch_issue_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    fetch_issue #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) bus.imem_q <= mem[bus.imem_addr];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.ready = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
        step(); step();
        n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", bus.instr); end
        n_cmp++; if (bus.isR !== 1'b1 || bus.opcode !== 5'd0) begin n_err++; $display("FAIL rst_decode: got isR=%b op=%h want 1/0", bus.isR, bus.opcode); end
        n_cmp++; if (bus.pc_out !== 12'h0 || bus.issued !== 4'd0) begin n_err++; $display("FAIL rst_pc_issued: got %h/%h want 0/0", bus.pc_out, bus.issued); end
        reset = 1'b0;
        n_cmp++; if (bus.imem_addr !== 12'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_first_issue();
        bus.ready = 1'b1;
        step();
        n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL first_wait_valid: got %b want 0", bus.valid); end
        step();
        n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", bus.valid); end
        n_cmp++; if (bus.opcode !== 5'b00101 || bus.isR !== 1'b0) begin n_err++; $display("FAIL first_decode: got op=%h isR=%b want 05/0", bus.opcode, bus.isR); end
        n_cmp++; if (bus.pc_out !== 12'h0 || bus.instr !== 32'h28000000) begin n_err++; $display("FAIL first_pc_instr: got %h/%h want 000/28000000", bus.pc_out, bus.instr); end
        step();
        n_cmp++; if (bus.issued !== 4'd1 || bus.valid !== 1'b0) begin n_err++; $display("FAIL first_accept: got issued=%0d valid=%b want 1/0", bus.issued, bus.valid); end
        n_cmp++; if (bus.imem_addr !== 12'h1) begin n_err++; $display("FAIL first_next_addr: got %h want 001", bus.imem_addr); end
    endtask

    task automatic test_stall();
        bus.ready = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.valid !== 1'b1 || bus.instr !== 32'h0 || bus.pc_out !== 12'h1) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b i=%h pc=%h want 1/0/001", i, bus.valid, bus.instr, bus.pc_out); end
            n_cmp++; if (bus.issued !== 4'd1 || bus.isR !== 1'b1) begin n_err++; $display("FAIL stall_cnt[%0d]: got issued=%0d isR=%b want 1/1", i, bus.issued, bus.isR); end
            step();
        end
        bus.ready = 1'b1;
        step();
        n_cmp++; if (bus.issued !== 4'd2 || bus.imem_addr !== 12'h2) begin n_err++; $display("FAIL stall_release: got issued=%0d addr=%h want 2/002", bus.issued, bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        step();
        bus.redirect = 1'b1; bus.redirect_target = 12'h040;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.valid !== 1'b0 || bus.imem_addr !== 12'h040 || bus.issued !== 4'd2) begin n_err++; $display("FAIL rdw_restart: got v=%b addr=%h issued=%0d want 0/040/2", bus.valid, bus.imem_addr, bus.issued); end
        step();
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rdw_stale: got %h want 00000000", bus.instr); end
        step();
        n_cmp++; if (bus.valid !== 1'b1 || bus.pc_out !== 12'h040 || bus.instr !== 32'h10000040) begin n_err++; $display("FAIL rdw_new: got v=%b pc=%h i=%h want 1/040/10000040", bus.valid, bus.pc_out, bus.instr); end
        n_cmp++; if (bus.opcode !== 5'd2) begin n_err++; $display("FAIL rdw_opcode: got %h want 02", bus.opcode); end
    endtask

    task automatic test_redirect_priority();
        bus.redirect = 1'b1; bus.redirect_target = 12'h005;
        step();
        bus.redirect = 1'b0; bus.ready = 1'b0;
        n_cmp++; if (bus.issued !== 4'd2 || bus.imem_addr !== 12'h005) begin n_err++; $display("FAIL rdp_to5: got issued=%0d addr=%h want 2/005", bus.issued, bus.imem_addr); end
        step(); step();
        n_cmp++; if (bus.valid !== 1'b1 || bus.pc_out !== 12'h005 || bus.opcode !== 5'd1) begin n_err++; $display("FAIL rdp_at5: got v=%b pc=%h op=%h want 1/005/01", bus.valid, bus.pc_out, bus.opcode); end
        bus.redirect = 1'b1; bus.ready = 1'b1; bus.redirect_target = 12'h0A0;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.valid !== 1'b0 || bus.imem_addr !== 12'h0A0 || bus.issued !== 4'd2) begin n_err++; $display("FAIL rdp_prio: got v=%b addr=%h issued=%0d want 0/0a0/2", bus.valid, bus.imem_addr, bus.issued); end
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1; bus.redirect_target = 12'hFFF;
        step();
        bus.redirect = 1'b0; bus.ready = 1'b1;
        step(); step();
        n_cmp++; if (bus.valid !== 1'b1 || bus.pc_out !== 12'hFFF || bus.opcode !== 5'h1F) begin n_err++; $display("FAIL wrap_issue: got v=%b pc=%h op=%h want 1/fff/1f", bus.valid, bus.pc_out, bus.opcode); end
        step();
        n_cmp++; if (bus.imem_addr !== 12'h000 || bus.issued !== 4'd3) begin n_err++; $display("FAIL wrap_addr: got addr=%h issued=%0d want 000/3", bus.imem_addr, bus.issued); end
    endtask

    task automatic test_reset_mid_issue();
        bus.ready = 1'b0;
        step(); step();
        n_cmp++; if (bus.valid !== 1'b1 || bus.instr !== 32'h28000000) begin n_err++; $display("FAIL rmi_pre: got v=%b i=%h want 1/28000000", bus.valid, bus.instr); end
        reset = 1'b1; bus.ready = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 12'h123;
        step();
        reset = 1'b0; bus.ready = 1'b0; bus.redirect = 1'b0;
        n_cmp++; if (bus.valid !== 1'b0 || bus.pc_out !== 12'h0 || bus.issued !== 4'd0 || bus.imem_addr !== 12'h0) begin n_err++; $display("FAIL rmi_post: got v=%b pc=%h issued=%0d addr=%h want 0/000/0/000", bus.valid, bus.pc_out, bus.issued, bus.imem_addr); end
        n_cmp++; if (bus.instr !== 32'h0 || bus.isR !== 1'b1) begin n_err++; $display("FAIL rmi_instr: got i=%h isR=%b want 0/1", bus.instr, bus.isR); end
    endtask

    task automatic test_back_to_back();
        bus.ready = 1'b1;
        for (int i = 0; i < 45; i++) step();
        n_cmp++; if (bus.issued !== 4'd15 || bus.imem_addr !== 12'd15) begin n_err++; $display("FAIL b2b_rate: got issued=%0d addr=%h want 15/00f", bus.issued, bus.imem_addr); end
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (bus.issued !== 4'd15 || bus.imem_addr !== 12'd17) begin n_err++; $display("FAIL b2b_sat: got issued=%0d addr=%h want 15/011", bus.issued, bus.imem_addr); end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[0]     = 32'h28000000;
        mem[2]     = 32'hDEADBEEF;
        mem[5]     = 32'h08000005;
        mem[12'h040] = 32'h10000040;
        mem[12'hFFF] = 32'hF8000000;
        test_reset();
        test_first_issue();
        test_stall();
        test_redirect_wait();
        test_redirect_priority();
        test_wrap();
        test_reset_mid_issue();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
